i2c_slave: RTL and testbench

- I2C target (responder) for the master on the same two-wire bus; single 7-bit address.
- Oversamples SCL/SDA on clk, detects START/repeated START/STOP, and ACKs its address.
- Delivers written bytes to fabric on a valid strobe; requests read bytes from fabric on a load strobe.
- Used as the on-chip peer of the I2C master for loopback and as a register-access port.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_line_cond.sv | 62 ++++++
 rtl/i2c_slave.sv | 199 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
// Contents: state enum i2c_slave_state_e, byte/synchronizer/filter sizes.
// Optional feature macro used by this slice: I2C_SLAVE_GLITCH_FILTER_EN.
package i2c_pkg;

    localparam int unsigned BYTE_BITS   = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILTER_LEN  = 3;
    localparam int unsigned CNT_W       = $clog2(BYTE_BITS);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } i2c_slave_state_e;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one asynchronous bus line: 2-FF synchronizer (reset to 1),
// optional 3-sample stable filter, and level/rise/fall outputs.
// Ports:
//   clk, reset  - system clock, async active-high reset
//   line_in     - raw bus line
//   level_c     - conditioned line level
//   rise_c      - one-cycle pulse on a 0->1 change of level_c
//   fall_c      - one-cycle pulse on a 1->0 change of level_c
// Macro I2C_SLAVE_GLITCH_FILTER_EN enables the stable filter (+2 clk latency).
module i2c_line_cond
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level_c,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   prev_q;

    // Metastability synchronizer; idle bus level is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [FILTER_LEN-2:0] hist_q;
    logic                  filt_q;

    // Level follows the input only after FILTER_LEN equal consecutive samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '1;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[FILTER_LEN-3:0], sync_out};
            filt_q <= level_c;
        end
    end

    assign level_c = (hist_q == {(FILTER_LEN-1){sync_out}}) ? sync_out : filt_q;
`else
    assign level_c = sync_out;
`endif

    // Previous-sample register for edge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= 1'b1;
        else       prev_q <= level_c;
    end

    assign rise_c = level_c & ~prev_q;
    assign fall_c = ~level_c & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a single 7-bit address. Detects START/repeated START/STOP,
// ACKs its address, delivers written bytes and requests bytes to read.
// Ports:
//   clk, reset - system clock, async active-high reset
//   SCL        - bus clock from master
//   SDA        - open-drain data, driven 0 or released (z)
//   tx_data    - byte returned on read, captured in the tx_load cycle
//   tx_load    - one-cycle request pulse for tx_data
//   rx_data    - last received data byte
//   rx_valid   - one-cycle pulse, rx_data valid
//   rx_ready   - sampled at rx_valid: 1 ACKs the byte, 0 NACKs it
//   busy       - high from address match until STOP or START
// Optional macro: I2C_SLAVE_GLITCH_FILTER_EN (line glitch filter).
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SCL,
    inout  wire                  SDA,
    input  logic [BYTE_BITS-1:0] tx_data,
    output logic                 tx_load,
    output logic [BYTE_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_BITS - 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_c, stop_c;

    i2c_slave_state_e     state_q, state_n;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_n;
    logic [BYTE_BITS-1:0] shift_q, shift_n;
    logic                 byte_full_q, byte_full_n;
    logic                 sda_low_q, sda_low_n;
    logic                 rw_q, rw_n;
    logic                 ack_q, ack_n;
    logic                 mack_q, mack_n;
    logic                 busy_n, rx_valid_n, tx_load_n;
    logic [BYTE_BITS-1:0] rx_data_n;

    i2c_line_cond u_scl (.clk(clk), .reset(reset), .line_in(SCL),
                         .level_c(scl_lvl), .rise_c(scl_rise), .fall_c(scl_fall));
    i2c_line_cond u_sda (.clk(clk), .reset(reset), .line_in(SDA),
                         .level_c(sda_lvl), .rise_c(sda_rise), .fall_c(sda_fall));

    assign SDA     = sda_low_q ? 1'b0 : 1'bz;
    assign start_c = sda_fall & scl_lvl;
    assign stop_c  = sda_rise & scl_lvl;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_full_q <= 1'b0;
            sda_low_q   <= 1'b0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            mack_q      <= 1'b1;
            busy        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_load     <= 1'b0;
        end else begin
            state_q     <= state_n;
            bit_cnt_q   <= bit_cnt_n;
            shift_q     <= shift_n;
            byte_full_q <= byte_full_n;
            sda_low_q   <= sda_low_n;
            rw_q        <= rw_n;
            ack_q       <= ack_n;
            mack_q      <= mack_n;
            busy        <= busy_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            tx_load     <= tx_load_n;
        end
    end

    // Next-state and output decode; START/STOP override any SCL edge.
    always_comb begin
        state_n     = state_q;
        bit_cnt_n   = bit_cnt_q;
        shift_n     = shift_q;
        byte_full_n = byte_full_q;
        sda_low_n   = sda_low_q;
        rw_n        = rw_q;
        ack_n       = ack_q;
        mack_n      = mack_q;
        busy_n      = busy;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        tx_load_n   = 1'b0;

        if (rx_valid) ack_n = rx_ready;

        if (stop_c) begin
            state_n     = IDLE;
            sda_low_n   = 1'b0;
            busy_n      = 1'b0;
            byte_full_n = 1'b0;
        end else if (start_c) begin
            state_n     = ADDR;
            bit_cnt_n   = '0;
            sda_low_n   = 1'b0;
            busy_n      = 1'b0;
            byte_full_n = 1'b0;
        end else begin
            case (state_q)
                ADDR, WRITE: begin
                    if (scl_rise) begin
                        shift_n   = {shift_q[BYTE_BITS-2:0], sda_lvl};
                        bit_cnt_n = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            byte_full_n = 1'b1;
                            if (state_q == WRITE) begin
                                rx_data_n  = {shift_q[BYTE_BITS-2:0], sda_lvl};
                                rx_valid_n = 1'b1;
                            end
                        end
                    end else if (scl_fall && byte_full_q) begin
                        // byte_full distinguishes the post-byte fall from the one right after START.
                        byte_full_n = 1'b0;
                        if (state_q == WRITE) begin
                            sda_low_n = ack_q;
                            state_n   = WRITE_ACK;
                        end else if (shift_q[BYTE_BITS-1:1] == SLAVE_ADDR) begin
                            sda_low_n = 1'b1;
                            busy_n    = 1'b1;
                            rw_n      = shift_q[0];
                            state_n   = ADDR_ACK;
                        end else begin
                            state_n   = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_low_n = 1'b0;
                        bit_cnt_n = '0;
                        if (rw_q) begin
                            tx_load_n = 1'b1;
                            state_n   = READ;
                        end else begin
                            state_n   = WRITE;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_low_n = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = WRITE;
                    end
                end
                READ: begin
                    // tx_data is captured in the tx_load cycle, so bit7 goes out one clk after the fall.
                    if (tx_load) begin
                        shift_n   = tx_data;
                        sda_low_n = ~tx_data[BYTE_BITS-1];
                    end else if (scl_fall) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            sda_low_n = 1'b0;
                            bit_cnt_n = '0;
                            state_n   = READ_ACK;
                        end else begin
                            sda_low_n = ~shift_q[BYTE_BITS-2];
                            shift_n   = {shift_q[BYTE_BITS-2:0], 1'b0};
                            bit_cnt_n = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        mack_n = sda_lvl;
                    end else if (scl_fall) begin
                        if (!mack_q) begin
                            tx_load_n = 1'b1;
                            bit_cnt_n = '0;
                            state_n   = READ;
                        end else begin
                            state_n   = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bit-banged bus master drives directed
// and randomized transactions; a transaction-level model predicts ACK slots,
// received bytes, tx_load requests and busy.
module tb_i2c_slave;

    localparam int unsigned Q = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       master_low;
    wire        sda_bus;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;

    assign sda_bus = master_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk(clk), .reset(reset), .SCL(scl), .SDA(sda_bus),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_got[$], rx_exp[$], tx_got[$], tx_exp[$];
    logic [7:0] wbuf[4];
    logic [7:0] rbuf[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record every fabric-side strobe with its data.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) rx_got.push_back(rx_data);
            if (tx_load)  tx_got.push_back(tx_data);
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_cond();
        master_low = 1'b0; wait_q();
        scl = 1'b1;        wait_q();
        master_low = 1'b1; wait_q();
        scl = 1'b0;        wait_q();
    endtask

    task automatic stop_cond();
        master_low = 1'b1; wait_q();
        scl = 1'b1;        wait_q();
        master_low = 1'b0; wait_q();
        wait_q();
    endtask

    // One SCL period; returns the bus level sampled mid-high. Optional 2-clk low glitch.
    task automatic send_bit(input logic b, input bit glitch, output logic s);
        master_low = ~b; wait_q();
        scl = 1'b1;      wait_q();
        s = sda_bus;
        if (glitch) begin
            master_low = 1'b1;
            repeat (2) @(negedge clk);
            master_low = ~b;
        end
        wait_q();
        scl = 1'b0;      wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        logic s;
        for (int i = 0; i < 8; i++) send_bit(b[7-i], i == glitch_bit, s);
        send_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] b);
        logic s;
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 1'b0, s);
            v = {v[6:0], s};
        end
        tx_data = next_tx;
        send_bit(nack, 1'b0, s);
        b = v;
    endtask

    task automatic verify_queues();
        check("rx_count", 32'(rx_got.size()), 32'(rx_exp.size()));
        for (int i = 0; i < rx_got.size() && i < rx_exp.size(); i++)
            check("rx_byte", 32'(rx_got[i]), 32'(rx_exp[i]));
        check("tx_load_count", 32'(tx_got.size()), 32'(tx_exp.size()));
        for (int i = 0; i < tx_got.size() && i < tx_exp.size(); i++)
            check("tx_load_data", 32'(tx_got[i]), 32'(tx_exp[i]));
        rx_got.delete(); rx_exp.delete(); tx_got.delete(); tx_exp.delete();
    endtask

    // Master write of wbuf[0..n-1]; model: ACK only our address, data ACK follows rx_ready.
    task automatic do_write(input logic [6:0] addr, input int n, input logic rdy,
                            input int glitch_bit, input bit do_stop);
        logic ack;
        bit   hit, alive;
        hit   = (addr == 7'h50);
        alive = hit;
        rx_ready = rdy;
        start_cond();
        write_byte({addr, 1'b0}, -1, ack);
        check("wr_addr_ack", 32'(ack), hit ? 32'd0 : 32'd1);
        check("wr_busy", 32'(busy), 32'(hit));
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], (i == 0) ? glitch_bit : -1, ack);
`ifndef I2C_SLAVE_GLITCH_FILTER_EN
            // An unfiltered glitch is a START followed by a STOP: the target goes idle.
            if (i == 0 && glitch_bit >= 0) alive = 1'b0;
`endif
            check("wr_data_ack", 32'(ack), (alive && rdy) ? 32'd0 : 32'd1);
            if (alive) rx_exp.push_back(wbuf[i]);
        end
        if (do_stop) begin
            stop_cond();
            check("wr_busy_stop", 32'(busy), 32'd0);
        end
        verify_queues();
    endtask

    // Master read of n bytes; rbuf[i] is offered on tx_data for the i-th request.
    task automatic do_read(input int n);
        logic       ack;
        logic [7:0] b;
        tx_data = rbuf[0];
        start_cond();
        write_byte({7'h50, 1'b1}, -1, ack);
        check("rd_addr_ack", 32'(ack), 32'd0);
        check("rd_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, (i < n - 1) ? rbuf[i+1] : 8'($urandom), b);
            check("rd_byte", 32'(b), 32'(rbuf[i]));
            tx_exp.push_back(rbuf[i]);
        end
        check("rd_release_after_nack", 32'(sda_bus), 32'd1);
        stop_cond();
        check("rd_busy_stop", 32'(busy), 32'd0);
        verify_queues();
    endtask

    initial begin
        #(900_000);
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack, s;
        int   n;

        reset = 1'b1; scl = 1'b1; master_low = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_sda", 32'(sda_bus), 32'd1);
        check("rst_tx_load", 32'(tx_load), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Write A5,3C to our address.
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        do_write(7'h50, 2, 1'b1, -1, 1'b1);

        // Foreign address: ignored.
        wbuf[0] = 8'h99;
        do_write(7'h51, 1, 1'b1, -1, 1'b1);

        // Read C3,5A; master NACKs the last byte.
        rbuf[0] = 8'hC3; rbuf[1] = 8'h5A;
        do_read(2);

        // Write 10, repeated START, read.
        wbuf[0] = 8'h10;
        do_write(7'h50, 1, 1'b1, -1, 1'b0);
        rbuf[0] = 8'($urandom);
        do_read(1);

        // rx_ready low NACKs but still strobes.
        wbuf[0] = 8'h77;
        do_write(7'h50, 1, 1'b0, -1, 1'b1);

        // Reset in the middle of a read byte (target driving 0).
        tx_data = 8'h00;
        start_cond();
        write_byte({7'h50, 1'b1}, -1, ack);
        check("rst_rd_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, s);
        scl = 1'b1;
        wait_q();
        check("rst_pre_drive", 32'(sda_bus), 32'd0);
        reset = 1'b1;
        #1;
        check("rst_mid_sda", 32'(sda_bus), 32'd1);
        check("rst_mid_tx_load", 32'(tx_load), 32'd0);
        check("rst_mid_rx_data", 32'(rx_data), 32'd0);
        check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_q();
        tx_exp.push_back(8'h00);
        verify_queues();
        wbuf[0] = 8'($urandom);
        do_write(7'h50, 1, 1'b1, -1, 1'b1);

        // 2-clk SDA glitch while SCL high inside a data byte of all ones.
        wbuf[0] = 8'hFF;
        do_write(7'h50, 1, 1'b1, 3, 1'b1);

        // Randomized transactions.
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(7'h50, n, 1'($urandom_range(0, 1)), -1, 1'b1);
            end else begin
                for (int i = 0; i < n; i++) rbuf[i] = 8'($urandom);
                do_read(n);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
